// File: rtl/amo_req_adapter_pkg.sv
// Shared types for the OBI-to-AMO-shim adapter.
//  amo_op_t   : 4-bit AMO code understood by the 64-bit shim (shared with it)
//  FUNCT5_*   : RISC-V A-extension funct5 encodings carried on data_atop[4:0]
//  resp_src_t : where the core response data comes from
//  decode_funct5 : funct5 -> amo_op_t (LR/SC/unknown map to AMO_NONE)
package amo_req_adapter_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_SWAP = 4'd1,
    AMO_ADD  = 4'd2,
    AMO_AND  = 4'd3,
    AMO_OR   = 4'd4,
    AMO_XOR  = 4'd5,
    AMO_MAX  = 4'd6,
    AMO_MAXU = 4'd7,
    AMO_MIN  = 4'd8,
    AMO_MINU = 4'd9
  } amo_op_t;

  localparam logic [4:0] FUNCT5_LR   = 5'b00010;
  localparam logic [4:0] FUNCT5_SC   = 5'b00011;
  localparam logic [4:0] FUNCT5_SWAP = 5'b00001;
  localparam logic [4:0] FUNCT5_ADD  = 5'b00000;
  localparam logic [4:0] FUNCT5_AND  = 5'b01100;
  localparam logic [4:0] FUNCT5_OR   = 5'b01000;
  localparam logic [4:0] FUNCT5_XOR  = 5'b00100;
  localparam logic [4:0] FUNCT5_MAX  = 5'b10100;
  localparam logic [4:0] FUNCT5_MAXU = 5'b11100;
  localparam logic [4:0] FUNCT5_MIN  = 5'b10000;
  localparam logic [4:0] FUNCT5_MINU = 5'b11000;

  typedef enum logic [1:0] {
    SRC_MEM     = 2'd0,
    SRC_SC_OK   = 2'd1,
    SRC_SC_FAIL = 2'd2
  } resp_src_t;

  function automatic amo_op_t decode_funct5(input logic [4:0] f5);
    amo_op_t op;
    case (f5)
      FUNCT5_SWAP: op = AMO_SWAP;
      FUNCT5_ADD:  op = AMO_ADD;
      FUNCT5_AND:  op = AMO_AND;
      FUNCT5_OR:   op = AMO_OR;
      FUNCT5_XOR:  op = AMO_XOR;
      FUNCT5_MAX:  op = AMO_MAX;
      FUNCT5_MAXU: op = AMO_MAXU;
      FUNCT5_MIN:  op = AMO_MIN;
      FUNCT5_MINU: op = AMO_MINU;
      default:     op = AMO_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/amo_req_adapter_if.sv
// Bus bundles for the adapter.
//  amo_obi_if : 32-bit OBI data port with atop. master = core, slave = adapter.
//    req/addr/we/be/wdata/atop from core; gnt/rvalid/rdata to core.
//  amo_mem_if : 64-bit AMO shim port. master = adapter, slave = shim.
//    req/add/amo/wen/wdata/be to shim; gnt/rdata from shim (rdata valid cycle after grant).
interface amo_obi_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [5:0]  atop;
  logic [31:0] rdata;

  modport master (output req, addr, we, be, wdata, atop, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, atop, output gnt, rvalid, rdata);
endinterface

interface amo_mem_if
  import amo_req_adapter_pkg::*;
#(
  parameter int AddrMemWidth = 20
) ();
  logic                    req;
  logic                    gnt;
  logic [AddrMemWidth-1:0] add;
  amo_op_t                 amo;
  logic                    wen;
  logic [63:0]             wdata;
  logic [7:0]              be;
  logic [63:0]             rdata;

  modport master (output req, add, amo, wen, wdata, be, input gnt, rdata);
  modport slave  (input req, add, amo, wen, wdata, be, output gnt, rdata);
endinterface

// File: rtl/amo_req_adapter_lrsc_reservation.sv
// LR/SC reservation: one valid bit, the reserved 64-bit word address
// (byte addr[31:3]) and a countdown that kills the reservation after
// ResvTimeout cycles (0 = never expires).
//  clk_i, rst_ni : clock, synchronous active-low reset
//  set_i         : granted LR -> (re)load address and counter
//  clear_i       : granted SC, or granted write to the reserved word
//  addr_i        : word address of the current request (set and compare)
//  valid_o       : reservation held
//  match_o       : valid and addr_i equals the reserved word
//  expiring_o    : last live cycle (counter at 1)
module amo_req_adapter_lrsc_reservation #(
  parameter int ResvTimeout = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        set_i,
  input  logic        clear_i,
  input  logic [28:0] addr_i,
  output logic        valid_o,
  output logic        match_o,
  output logic        expiring_o
);

  localparam int CntW = (ResvTimeout > 1) ? $clog2(ResvTimeout + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(ResvTimeout);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam bit Expires = (ResvTimeout != 0);

  logic            valid_q, valid_d;
  logic [28:0]     addr_q, addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state: LR set wins, then clear, then countdown while held.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      cnt_d   = CntLoad;
    end else if (clear_i) begin
      valid_d = 1'b0;
      cnt_d   = {CntW{1'b0}};
    end else if (valid_q && Expires) begin
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Reservation state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= 29'd0;
      cnt_q   <= {CntW{1'b0}};
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o    = valid_q;
  assign match_o    = valid_q && (addr_q == addr_i);
  assign expiring_o = Expires && valid_q && (cnt_q == CntOne);

endmodule

// File: rtl/amo_req_adapter.sv
// Adapter between a core's 32-bit OBI data port (with A-extension atop) and
// the 64-bit AMO shim in front of the SRAM. Maps atop to the shim AMO code,
// steers lanes/byte enables, and resolves LR/SC locally against a reservation.
//  clk_i, rst_ni : clock, synchronous active-low reset
//  core_bus      : amo_obi_if.slave  (core request / response)
//  mem_bus       : amo_mem_if.master (shim request, rdata a cycle after grant)
// Parameters: AddrMemWidth (word address width), ResvTimeout (0 = no expiry).
module amo_req_adapter
  import amo_req_adapter_pkg::*;
#(
  parameter int AddrMemWidth = 20,
  parameter int ResvTimeout  = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  amo_obi_if.slave   core_bus,
  amo_mem_if.master  mem_bus
);

  amo_op_t   amo_s;
  logic      is_lr_s, is_sc_s, sc_fail_s, wen_s, lane_s;
  logic      granted_s, is_write_s, resv_set_s, resv_clear_s;
  logic      resv_valid_s, resv_match_s, resv_expiring_s;
  logic      rvalid_q, lane_q, lane_d;
  resp_src_t src_q, src_d;
  logic [31:0] rdata_s;

  // Decode atop into shim op and LR/SC flags.
  always_comb begin
    amo_s   = AMO_NONE;
    is_lr_s = 1'b0;
    is_sc_s = 1'b0;
    if (core_bus.atop[5]) begin
      amo_s   = decode_funct5(core_bus.atop[4:0]);
      is_lr_s = (core_bus.atop[4:0] == FUNCT5_LR);
      is_sc_s = (core_bus.atop[4:0] == FUNCT5_SC);
    end else begin
      amo_s = AMO_NONE;
    end
  end

  // Write enable: AMOs and LR read, SC writes, everything else follows we.
  always_comb begin
    wen_s = core_bus.we;
    if (amo_s != AMO_NONE || is_lr_s) begin
      wen_s = 1'b0;
    end else if (is_sc_s) begin
      wen_s = 1'b1;
    end else begin
      wen_s = core_bus.we;
    end
  end

  // An SC that loses its reservation (including in the expiry cycle) never
  // reaches memory and is granted immediately.
  assign sc_fail_s = is_sc_s && !(resv_match_s && !resv_expiring_s);

  assign lane_s        = core_bus.addr[2];
  assign mem_bus.req   = core_bus.req && !sc_fail_s;
  assign mem_bus.add   = core_bus.addr[AddrMemWidth+2:3];
  assign mem_bus.amo   = amo_s;
  assign mem_bus.wen   = wen_s;
  assign mem_bus.wdata = {core_bus.wdata, core_bus.wdata};
  assign mem_bus.be    = lane_s ? {core_bus.be, 4'h0} : {4'h0, core_bus.be};
  assign core_bus.gnt  = sc_fail_s ? core_bus.req : mem_bus.gnt;

  assign granted_s    = core_bus.req && core_bus.gnt;
  assign is_write_s   = (amo_s != AMO_NONE) || (wen_s && !is_sc_s);
  assign resv_set_s   = granted_s && is_lr_s;
  assign resv_clear_s = granted_s && (is_sc_s || (is_write_s && resv_match_s));

  amo_req_adapter_lrsc_reservation #(
    .ResvTimeout (ResvTimeout)
  ) u_resv (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (resv_set_s),
    .clear_i    (resv_clear_s),
    .addr_i     (core_bus.addr[31:3]),
    .valid_o    (resv_valid_s),
    .match_o    (resv_match_s),
    .expiring_o (resv_expiring_s)
  );

  // Response source and lane, captured only on grant.
  always_comb begin
    lane_d = lane_q;
    src_d  = src_q;
    if (granted_s) begin
      lane_d = lane_s;
      if (sc_fail_s) begin
        src_d = SRC_SC_FAIL;
      end else if (is_sc_s) begin
        src_d = SRC_SC_OK;
      end else begin
        src_d = SRC_MEM;
      end
    end else begin
      src_d = src_q;
    end
  end

  // Response tracking registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      lane_q   <= 1'b0;
      src_q    <= SRC_MEM;
    end else begin
      rvalid_q <= granted_s;
      lane_q   <= lane_d;
      src_q    <= src_d;
    end
  end

  // Response data: shim rdata arrives the cycle after grant, so it is
  // selected live; SC outcome is encoded as 0 (success) / 1 (failure).
  always_comb begin
    rdata_s = 32'h0;
    if (rvalid_q) begin
      case (src_q)
        SRC_MEM:     rdata_s = lane_q ? mem_bus.rdata[63:32] : mem_bus.rdata[31:0];
        SRC_SC_FAIL: rdata_s = 32'h1;
        SRC_SC_OK:   rdata_s = 32'h0;
        default:     rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign core_bus.rvalid = rvalid_q;
  assign core_bus.rdata  = rdata_s;

  logic unused_s;
  assign unused_s = resv_valid_s;

endmodule

// File: tb/tb_amo_req_adapter.sv
// Directed bench for amo_req_adapter with a small behavioural AMO shim/SRAM.
module tb_amo_req_adapter;
  import amo_req_adapter_pkg::*;

  localparam int AW = 20;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  amo_obi_if core_bus ();
  amo_mem_if #(.AddrMemWidth(AW)) mem_bus ();

  amo_req_adapter #(.AddrMemWidth(AW), .ResvTimeout(TO)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .core_bus (core_bus),
    .mem_bus  (mem_bus)
  );

  // ---------------- shim / SRAM model ----------------
  logic [63:0] mem [0:255];
  logic [63:0] mem_rdata_q;
  bit          stall;
  bit          poke_en;
  logic [7:0]  poke_addr;
  logic [63:0] poke_data;

  assign mem_bus.gnt   = ~stall;
  assign mem_bus.rdata = mem_rdata_q;

  function automatic logic [63:0] shim_update(input logic [63:0] old, input logic [3:0] amo,
                                              input logic wen, input logic [7:0] be,
                                              input logic [63:0] wd);
    logic [63:0] r;
    logic [31:0] a, b, x;
    logic hi;
    r  = old;
    hi = be[4];
    a  = hi ? old[63:32] : old[31:0];
    b  = hi ? wd[63:32] : wd[31:0];
    x  = a;
    case (amo)
      4'd1: x = b;
      4'd2: x = a + b;
      4'd3: x = a & b;
      4'd4: x = a | b;
      4'd5: x = a ^ b;
      4'd6: x = ($signed(a) > $signed(b)) ? a : b;
      4'd7: x = (a > b) ? a : b;
      4'd8: x = ($signed(a) < $signed(b)) ? a : b;
      4'd9: x = (a < b) ? a : b;
      default: x = a;
    endcase
    if (amo != 4'd0) begin
      if (hi) r[63:32] = x;
      else    r[31:0]  = x;
    end else if (wen) begin
      for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mem_bus.req && mem_bus.gnt) begin
      mem_rdata_q         <= mem[mem_bus.add[7:0]];
      mem[mem_bus.add[7:0]] <= shim_update(mem[mem_bus.add[7:0]], mem_bus.amo, mem_bus.wen,
                                           mem_bus.be, mem_bus.wdata);
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [31:0]   x_rdata;
  bit            x_memreq;
  int            x_wait;
  logic [7:0]    x_be;
  logic [3:0]    x_amo;
  logic          x_wen;
  logic [AW-1:0] x_add;

  task automatic poke(input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One core transaction; called just after a negedge, returns just after the
  // negedge following the response cycle.
  task automatic xact(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [5:0] atop);
    bit done;
    done = 1'b0;
    core_bus.req = 1'b1; core_bus.addr = addr; core_bus.we = we;
    core_bus.be = be; core_bus.wdata = wdata; core_bus.atop = atop;
    x_memreq = 1'b0; x_wait = 0;
    #1;
    x_be = mem_bus.be; x_amo = mem_bus.amo; x_wen = mem_bus.wen; x_add = mem_bus.add;
    while (!done && x_wait < 16) begin
      if (mem_bus.req) x_memreq = 1'b1;
      if (core_bus.gnt) begin
        done = 1'b1;
      end else begin
        @(negedge clk); #1;
        x_wait++;
      end
    end
    if (!done) begin
      chk("gnt_timeout", 64'd0, 64'd1);
      core_bus.req = 1'b0;
      x_rdata = 32'hx;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    core_bus.req = 1'b0; core_bus.atop = 6'd0; core_bus.we = 1'b0;
    #1;
    chk("rvalid", {63'd0, core_bus.rvalid}, 64'd1);
    x_rdata = core_bus.rdata;
  endtask

  localparam logic [5:0] AT_ADD  = 6'b100000;
  localparam logic [5:0] AT_MAXU = 6'b111100;
  localparam logic [5:0] AT_LR   = 6'b100010;
  localparam logic [5:0] AT_SC   = 6'b100011;

  initial begin
    rst_n = 1'b0; stall = 1'b0; poke_en = 1'b0; poke_addr = 8'd0; poke_data = 64'd0;
    core_bus.req = 1'b0; core_bus.addr = 32'd0; core_bus.we = 1'b0;
    core_bus.be = 4'h0; core_bus.wdata = 32'd0; core_bus.atop = 6'd0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", {63'd0, core_bus.rvalid}, 64'd0);
    chk("rst_rdata", {32'd0, core_bus.rdata}, 64'd0);
    rst_n = 1'b1;

    poke(8'h20, 64'hAAAA_BBBB_1111_2222);
    poke(8'h40, 64'h0000_0000_0000_0007);
    poke(8'h41, 64'h0000_0010_0000_0000);
    poke(8'h60, 64'h0);
    poke(8'h61, 64'h0);

    // Upper-lane load
    xact(32'h104, 1'b0, 4'hF, 32'h0, 6'd0);
    chk("ld_be", {56'd0, x_be}, 64'hF0);
    chk("ld_add", {44'd0, x_add}, 64'h20);
    chk("ld_amo", {60'd0, x_amo}, 64'd0);
    chk("ld_rdata", {32'd0, x_rdata}, 64'hAAAA_BBBB);

    // AMOADD lower lane
    xact(32'h200, 1'b0, 4'hF, 32'd5, AT_ADD);
    chk("add_amo", {60'd0, x_amo}, 64'd2);
    chk("add_wen", {63'd0, x_wen}, 64'd0);
    chk("add_be", {56'd0, x_be}, 64'h0F);
    chk("add_rdata", {32'd0, x_rdata}, 64'd7);
    chk("add_mem", {32'd0, mem[8'h40][31:0]}, 64'd12);

    // LR / SC success, then repeated SC fails
    xact(32'h300, 1'b0, 4'hF, 32'd0, AT_LR);
    chk("lr_wen", {63'd0, x_wen}, 64'd0);
    xact(32'h300, 1'b1, 4'hF, 32'd9, AT_SC);
    chk("sc_memreq", {63'd0, x_memreq}, 64'd1);
    chk("sc_wen", {63'd0, x_wen}, 64'd1);
    chk("sc_rdata", {32'd0, x_rdata}, 64'd0);
    chk("sc_mem", mem[8'h60], 64'd9);
    xact(32'h300, 1'b1, 4'hF, 32'h77, AT_SC);
    chk("sc2_memreq", {63'd0, x_memreq}, 64'd0);
    chk("sc2_wait", x_wait, 64'd0);
    chk("sc2_rdata", {32'd0, x_rdata}, 64'd1);
    chk("sc2_mem", mem[8'h60], 64'd9);

    // Store to reserved word kills reservation
    xact(32'h300, 1'b0, 4'hF, 32'd0, AT_LR);
    xact(32'h304, 1'b1, 4'hF, 32'h1234, 6'd0);
    chk("st_be", {56'd0, x_be}, 64'hF0);
    chk("st_mem", mem[8'h60], 64'h0000_1234_0000_0009);
    xact(32'h300, 1'b1, 4'hF, 32'h99, AT_SC);
    chk("sc3_memreq", {63'd0, x_memreq}, 64'd0);
    chk("sc3_wait", x_wait, 64'd0);
    chk("sc3_rdata", {32'd0, x_rdata}, 64'd1);
    chk("sc3_mem", mem[8'h60], 64'h0000_1234_0000_0009);

    // Timeout: SC in expiry cycle fails, earlier SC succeeds
    xact(32'h300, 1'b0, 4'hF, 32'd0, AT_LR);
    repeat (3) @(negedge clk);
    xact(32'h300, 1'b1, 4'hF, 32'h55, AT_SC);
    chk("to_memreq", {63'd0, x_memreq}, 64'd0);
    chk("to_rdata", {32'd0, x_rdata}, 64'd1);
    xact(32'h300, 1'b0, 4'hF, 32'd0, AT_LR);
    @(negedge clk);
    xact(32'h300, 1'b1, 4'hF, 32'h42, AT_SC);
    chk("early_rdata", {32'd0, x_rdata}, 64'd0);
    chk("early_mem", mem[8'h60], 64'h0000_1234_0000_0042);

    // Store to a different word keeps the reservation
    xact(32'h300, 1'b0, 4'hF, 32'd0, AT_LR);
    xact(32'h308, 1'b1, 4'hF, 32'hDEAD, 6'd0);
    xact(32'h300, 1'b1, 4'hF, 32'h66, AT_SC);
    chk("other_rdata", {32'd0, x_rdata}, 64'd0);
    chk("other_mem", mem[8'h60], 64'h0000_1234_0000_0066);
    chk("other_st", mem[8'h61], 64'h0000_0000_0000_DEAD);

    // AMOMAXU upper lane with a two-cycle shim stall
    stall = 1'b1;
    fork
      xact(32'h20C, 1'b0, 4'hF, 32'h20, AT_MAXU);
      begin
        repeat (2) @(negedge clk);
        stall = 1'b0;
      end
    join
    chk("maxu_amo", {60'd0, x_amo}, 64'd7);
    chk("maxu_be", {56'd0, x_be}, 64'hF0);
    chk("maxu_wait", x_wait, 64'd2);
    chk("maxu_rdata", {32'd0, x_rdata}, 64'h10);
    chk("maxu_mem", mem[8'h41], 64'h0000_0020_0000_0000);

    // Reset during a stalled AMO
    xact(32'h300, 1'b0, 4'hF, 32'd0, AT_LR);
    stall = 1'b1;
    core_bus.req = 1'b1; core_bus.addr = 32'h200; core_bus.we = 1'b0;
    core_bus.be = 4'hF; core_bus.wdata = 32'd1; core_bus.atop = AT_ADD;
    #1;
    chk("stall_gnt", {63'd0, core_bus.gnt}, 64'd0);
    chk("stall_memreq", {63'd0, mem_bus.req}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_rvalid", {63'd0, core_bus.rvalid}, 64'd0);
    chk("rst2_rdata", {32'd0, core_bus.rdata}, 64'd0);
    chk("rst2_mem", mem[8'h40], 64'd12);
    rst_n = 1'b1; stall = 1'b0; core_bus.req = 1'b0; core_bus.atop = 6'd0;
    #1;
    xact(32'h300, 1'b1, 4'hF, 32'h88, AT_SC);
    chk("rst2_sc_memreq", {63'd0, x_memreq}, 64'd0);
    chk("rst2_sc_rdata", {32'd0, x_rdata}, 64'd1);
    chk("rst2_sc_mem", mem[8'h60], 64'h0000_1234_0000_0066);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
